// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 scan sequencer and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] ScExt      = 8'hE0;
    localparam logic [7:0] ScBreak    = 8'hF0;
    localparam logic [7:0] ScPause    = 8'hE1;
    localparam logic [7:0] ScBatOk    = 8'hAA;
    localparam logic [7:0] ScAck      = 8'hFA;
    localparam logic [7:0] ScEcho     = 8'hEE;
    localparam logic [7:0] ScResend   = 8'hFE;
    localparam logic [7:0] ScBatFail  = 8'hFC;
    localparam logic [7:0] ScOverrun0 = 8'h00;
    localparam logic [7:0] ScOverrunF = 8'hFF;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t StIdle   = 3'd0;
    localparam seq_state_t StExt    = 3'd1;
    localparam seq_state_t StBrk    = 3'd2;
    localparam seq_state_t StExtBrk = 3'd3;
    localparam seq_state_t StSkip   = 3'd4;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word fall-through FIFO of key events. When empty the output
// holds the most recently popped event.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  ps2_evt_t i_data,
    input  logic     i_pop,
    output ps2_evt_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CountFull = CntW'(Depth);

    ps2_evt_t            r_mem [Depth];
    ps2_evt_t            r_last;
    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [CntW-1:0]     r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_count == CountFull);
    assign o_empty   = (r_count == '0);
    // A pop frees a slot in the same cycle, so a push into a full FIFO still fits.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Folds set-2 prefix sequences (E0, F0, E1 pause) into single key events, queues them,
// and flushes the receiver on frame errors or inter-byte timeouts.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned E1_SKIP        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_err,
    output logic       rx_flush,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       overflow,
    output logic [7:0] err_count
);
    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SkipW  = $clog2(E1_SKIP + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [SkipW-1:0]  SkipInit  = SkipW'(E1_SKIP);

    seq_state_t        r_state;
    seq_state_t        w_state_d;
    logic [SkipW-1:0]  r_skip;
    logic [SkipW-1:0]  w_skip_d;
    logic [TimerW-1:0] r_timer;
    logic [TimerW-1:0] w_timer_d;
    logic              r_flush;
    logic              w_flush_d;
    logic [7:0]        r_err_count;
    logic              w_err_inc;
    logic              r_overflow;
    logic              w_push;
    ps2_evt_t          w_push_evt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    ps2_evt_t          w_head;

    always_comb begin
        w_state_d  = r_state;
        w_skip_d   = r_skip;
        w_flush_d  = 1'b0;
        w_err_inc  = 1'b0;
        w_push     = 1'b0;
        w_push_evt = '0;
        if (byte_err) begin
            w_state_d = StIdle;
            w_flush_d = 1'b1;
            w_err_inc = 1'b1;
        end else if (byte_valid) begin
            case (r_state)
                StIdle: begin
                    case (byte_data)
                        ScExt:   w_state_d = StExt;
                        ScBreak: w_state_d = StBrk;
                        ScPause: begin
                            w_state_d = StSkip;
                            w_skip_d  = SkipInit;
                        end
                        ScBatOk, ScAck, ScEcho, ScResend, ScBatFail: begin
                        end
                        ScOverrun0, ScOverrunF: w_err_inc = 1'b1;
                        default: begin
                            w_push     = 1'b1;
                            w_push_evt = '{code: byte_data, ext: 1'b0, brk: 1'b0};
                        end
                    endcase
                end
                StExt: begin
                    if (byte_data == ScBreak) begin
                        w_state_d = StExtBrk;
                    end else if (byte_data != ScExt) begin
                        w_push     = 1'b1;
                        w_push_evt = '{code: byte_data, ext: 1'b1, brk: 1'b0};
                        w_state_d  = StIdle;
                    end
                end
                StBrk: begin
                    w_push     = 1'b1;
                    w_push_evt = '{code: byte_data, ext: 1'b0, brk: 1'b1};
                    w_state_d  = StIdle;
                end
                StExtBrk: begin
                    w_push     = 1'b1;
                    w_push_evt = '{code: byte_data, ext: 1'b1, brk: 1'b1};
                    w_state_d  = StIdle;
                end
                StSkip: begin
                    if (r_skip <= SkipW'(1)) begin
                        w_push     = 1'b1;
                        w_push_evt = '{code: ScPause, ext: 1'b0, brk: 1'b0};
                        w_state_d  = StIdle;
                    end else begin
                        w_skip_d = r_skip - SkipW'(1);
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (r_state != StIdle && r_timer == TimerLast) begin
            w_state_d = StIdle;
            w_flush_d = 1'b1;
            w_err_inc = 1'b1;
        end

        // Timer only advances while a sequence is open and no byte arrives.
        if (w_state_d == StIdle || byte_valid) begin
            w_timer_d = '0;
        end else begin
            w_timer_d = r_timer + TimerW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_skip      <= '0;
            r_timer     <= '0;
            r_flush     <= 1'b0;
            r_err_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_skip  <= w_skip_d;
            r_timer <= w_timer_d;
            r_flush <= w_flush_d;
            if (w_err_inc && r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop     = !w_empty && evt_ready;
    assign evt_valid = !w_empty;
    assign evt_code  = w_head.code;
    assign evt_ext   = w_head.ext;
    assign evt_break = w_head.brk;
    assign rx_flush  = r_flush;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
- Controller downstream of the PS/2 frame receiver.
- Consumes validated scan bytes and sequences the multi-byte set-2 protocol (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events.
- Queues events in a small FIFO with a valid/ready handshake toward the key decoder.
- Supervises the receiver: issues a flush pulse on frame errors and on inter-byte timeouts so a desynchronised receiver recovers.

Parameters:
- FIFO_DEPTH, 4, number of queued key events (power of two, >= 2).
- TIMEOUT_CYCLES, 50000, clk cycles allowed between bytes of one sequence (1 ms at 50 MHz).
- E1_SKIP, 7, bytes discarded after an E1 prefix.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- byte_valid  in  1  one-cycle pulse: byte_data holds a received byte.
- byte_data  in  8  received scan byte.
- byte_err  in  1  one-cycle pulse: receiver saw a parity or stop-bit error (never coincident with byte_valid).
- rx_flush  out  1  one-cycle pulse commanding the receiver to return to idle.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head when evt_valid && evt_ready.
- evt_code  out  8  scan code of head event.
- evt_ext  out  1  head event was E0-prefixed.
- evt_break  out  1  head event is a release (F0-prefixed).
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- err_count  out  8  saturating count of frame errors plus timeouts.

Behaviour:
- Reset values: rx_flush=0, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, overflow=0, err_count=0, FSM=IDLE, FIFO empty, timer=0.
- Reset mid-sequence discards the partial sequence and FIFO contents. No flush pulse is issued.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> SKIP (skip count = E1_SKIP).
  - AA, FA, EE, FE, FC are discarded; stay in IDLE.
  - 00 or FF is a keyboard overrun: discard and increment err_count.
  - Any other byte: push {code, ext=0, brk=0}; stay in IDLE.
- EXT: F0 -> EXT_BRK; E0 is ignored (stay); any other byte: push {code, ext=1, brk=0} -> IDLE.
- BRK: push {code, ext=0, brk=1} -> IDLE.
- EXT_BRK: push {code, ext=1, brk=1} -> IDLE.
- SKIP: each byte decrements the skip count. On the byte that reaches 0, push {E1, ext=0, brk=0} -> IDLE.
- Timer:
  - Counts only in non-IDLE states; cleared on each byte_valid and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no byte_valid that cycle, FSM -> IDLE, rx_flush=1 for one cycle, err_count increments.
  - If byte_valid coincides with expiry, the byte wins and no timeout occurs.
- byte_err in any state: FSM -> IDLE, rx_flush=1 for one cycle, err_count increments, partial sequence discarded.
- err_count saturates at 255.
- Push latency: if the FIFO is empty, the event is visible on evt_* with evt_valid=1 in the cycle after the completing byte_valid.
- FIFO is first-word fall-through; evt_* hold the head and are stable while evt_valid && !evt_ready.
- Full FIFO with a push: accepted if a pop occurs the same cycle. Otherwise the event is dropped, overflow=1 (cleared only by reset), and FIFO contents are unchanged.
- Empty FIFO with a pop attempt: no effect. evt_* hold their last value; the consumer must qualify with evt_valid.
- Simultaneous push and pop with a non-full FIFO: both occur and the count is unchanged.

Decomposition:
- ps2_pkg holds:
  - prefix constants (E0, F0, E1, AA, FA, EE, FE, FC, 00, FF);
  - the sequencer state enum;
  - the packed event struct {code[7:0], ext, brk}.
- One sub-module, ps2_evt_fifo: parameterised synchronous FWFT FIFO carrying the event struct, with full/empty flags and push/pop ports. It has no protocol knowledge.

Test Plan:
- Byte 1C with evt_ready=1 -> evt_valid one cycle later with code=1C, ext=0, brk=0; popped the next cycle.
- Bytes E0,F0,75 (gaps of 100 cycles) -> a single event code=75, ext=1, brk=1; no rx_flush.
- Bytes E0 then silence for 50000 cycles -> rx_flush pulse exactly once, err_count=1, FSM in IDLE; following byte 1C gives code=1C, ext=0.
- evt_ready=0 and bytes 15,1D,24,2D,2C -> four events queued, fifth dropped, overflow=1; drain gives 15,1D,24,2D in order.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> exactly one event code=E1, ext=0, brk=0.
- Byte F0 then byte_err, then 1C -> rx_flush pulse, err_count=1, then event code=1C with brk=0; reset asserted mid-sequence clears all outputs to 0.
